ula_seq: RTL and testbench
==========================

# ula_seq

Parametrised, sequential successor to the 2-bit combinational `ula`. It extends the same 16-operation `Sel` map to W-bit operands and adds a start/done handshake, iterative multiply and divide, and variable shift and rotate amounts. Status flags are captured with each result. It sits between the operand registers and the result bus, and its owner holds operands stable only for the start cycle.

## Interface
- `W`, default 8: operand width, ≥ 2.
- `SHW`, default `$clog2(W)`: width of the shift/rotate amount taken from `B`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request. Sampled only while `busy`=0.
- `Sel` input 4: operation code.
- `A` input W: operand A. Captured on accepted `start`.
- `B` input W: operand B. Captured on accepted `start`.
- `Saida` output 2W: result. Held until the next `done`.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when `Saida` and the flags update.
- `zero` output 1: `Saida`==0. Valid with `done`, held after.
- `carry` output 1: carry out of add, or borrow out of sub. 0 for every other op.
- `div0` output 1: divide by zero occurred.

## Operation
- States: IDLE, RUN (multiply/divide only), FIN.
- IDLE with `start`=1: latch `Sel`, `A`, `B`. Single-cycle ops go to FIN. `Sel` 2/3 go to RUN, with iteration counter = W−1.
- RUN: one iteration per cycle. Counter 0 leads to FIN.
- FIN: write `Saida` and the flags, pulse `done`, return to IDLE.
- `Sel` map; all results are zero-extended to 2W:
  - 0: A+B, W+1 bits. `carry` = bit W.
  - 1: A−B mod 2^W in bits W-1:0. Bit W = borrow = `carry` (set when A<B).
  - 2: A*B unsigned, 2W bits. Shift-add, W iterations.
  - 3: unsigned restoring division, W iterations. Quotient in bits W-1:0, remainder in bits 2W-1:W.
    - B=0 takes no RUN cycles: quotient = all ones, remainder = A, `div0`=1.
  - 4: A << B[SHW-1:0], kept to W bits.
  - 5: A >> B[SHW-1:0], logical.
  - 6: rotate A right by B[SHW-1:0] within W bits.
  - 7: rotate A left by B[SHW-1:0] within W bits.
  - 8 through 13: bitwise AND, OR, XOR, NAND, NOR, XNOR of A and B, W bits.
  - 14: `Saida` = 1 if A>B unsigned, else 0.
  - 15: `Saida` = 1 if A==B, else 0.
- `carry` and `div0` are cleared on every `done` whose op does not set them.

## Timing
- Reset values: `Saida`=0, `busy`=0, `done`=0, `zero`=1, `carry`=0, `div0`=0. State is IDLE.
- Single-cycle ops:
  - `start` accepted at edge n.
  - `busy`=1 in cycle n+1.
  - `done`=1 and `Saida` valid in cycle n+1 (latency 1).
  - `busy`=0 from n+2.
- Multiply and divide (B≠0): `done` in cycle n+W+1. `busy`=1 from n+1 through n+W+1.
- Divide with B=0: latency 1.
- Back-to-back: `start` sampled in the `done` cycle is ignored. The next accept is at the earliest in the cycle after `done`, because `busy` is still 1 in the `done` cycle.
- `start` while `busy`=1 is ignored and not queued. Operand changes during RUN have no effect.
- Reset asserted mid-operation: the operation is aborted and every output returns to its reset value immediately, with no `done`.
- Sel values outside the map cannot occur, since all 16 codes are defined.

## Structure
- Package `ula_pkg`: 4-bit `Sel` constants `OP_ADD` … `OP_EQ` in the order above, and the FSM state enum.
- Sub-module `ula_muldiv`: iterative shift-add multiplier and restoring divider sharing one 2W accumulator.
  - Ports: `clk`, `rst_n`, `load`, `is_div`, `A`, `B`, `res`, `last`.
- The top level holds the FSM, the single-cycle combinational ops, and the result/flag registers.

## Test plan
All cases use W=8.
- Reset mid-multiply: assert `rst_n`=0 at the 4th RUN cycle → outputs return to reset values at once, no `done`. The next add, 1+1, gives `Saida`=2.
- Add and sub:
  - A=8'hFF, B=8'h01, Sel=0 → `Saida`=16'h0100, `carry`=1, `done` one cycle after start.
  - A=1, B=1, Sel=1 → `Saida`=0, `zero`=1, `carry`=0.
- Multiply: A=8'hFF, B=8'hFF, Sel=2 → `Saida`=16'hFE01 after exactly 9 cycles. A second `start` pulsed during RUN is ignored.
- Divide:
  - A=200, B=7, Sel=3 → `Saida`={8'd4, 8'd28}.
  - A=5, B=0 → `Saida`=16'h05FF, `div0`=1, latency 1.
- Shift and rotate:
  - A=8'h81, B=3, Sel=6 → `Saida`=8'h30.
  - Sel=7 → `Saida`=8'h0C.
  - Sel=4, A=8'h81, B=3 → `Saida`=8'h08.
- Logic and compare: sweep all 8–15 codes for A=8'hA5, B=8'h5A; check AND=0, OR=FF, NAND=FF, A>B gives 1, A==B gives 0. Then A=B=8'h33, Sel=15 → `Saida`=1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared operation codes and FSM state encoding for the sequential ULA.
package ula_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROR  = 4'd6,
    OP_ROL  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NAND = 4'd11,
    OP_NOR  = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ula_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle,
// sharing a single 2W accumulator. res is the accumulator value after this cycle's step.
module ula_muldiv #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           is_div,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] res,
  output logic           last
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_b;
  logic           r_div;
  logic           r_run;
  logic [CW-1:0]  r_cnt;

  logic [W:0]     w_sum;
  logic [W:0]     w_t;
  logic [W:0]     w_diff;

  always_comb begin
    w_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_b};
    w_t    = {r_acc[2*W-1:W], r_acc[W-1]};
    w_diff = w_t - {1'b0, r_b};
    res    = r_acc;
    if (!r_div) begin
      // multiplier bits drain out of the low half while the product fills in from the top
      if (r_acc[0]) res = {w_sum, r_acc[W-1:1]};
      else          res = {1'b0, r_acc[2*W-1:1]};
    end else begin
      if (!w_diff[W]) res = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else            res = {w_t[W-1:0],    r_acc[W-2:0], 1'b0};
    end
  end

  assign last = r_run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (load) begin
      r_acc <= {{W{1'b0}}, A};
      r_b   <= B;
      r_div <= is_div;
      r_run <= 1'b1;
      r_cnt <= CW'(W - 1);
    end else if (r_run) begin
      r_acc <= res;
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential W-bit ULA: start/done handshake, 16-op Sel map, iterative mul/div,
// result and status flags registered on completion.
module ula_seq
  import ula_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     Sel,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] Saida,
  output logic           busy,
  output logic           done,
  output logic           zero,
  output logic           carry,
  output logic           div0
);

  state_e         r_state;
  state_e         w_state_nxt;

  logic [2*W-1:0] r_saida;
  logic           r_zero;
  logic           r_carry;
  logic           r_div0;

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [SHW-1:0] w_amt;
  logic [SHW-1:0] w_rot;
  logic [2*W-1:0] w_rr;
  logic [2*W-1:0] w_rl;
  logic [2*W-1:0] w_single;
  logic           w_scarry;
  logic           w_sdiv0;
  logic           w_iter;
  logic           w_is_div;

  logic [2*W-1:0] w_md_res;
  logic           w_last;
  logic           w_load;
  logic           w_write;
  logic [2*W-1:0] w_wdata;
  logic           w_wcarry;
  logic           w_wdiv0;

  // Single-cycle ops are evaluated straight from the inputs in the accept cycle,
  // so only mul/div need operands held internally.
  always_comb begin
    w_add    = {1'b0, A} + {1'b0, B};
    w_sub    = {1'b0, A} - {1'b0, B};
    w_amt    = B[SHW-1:0];
    w_rot    = SHW'(w_amt % W);
    w_rr     = {A, A} >> w_rot;
    w_rl     = {A, A} << w_rot;
    w_single = '0;
    w_scarry = 1'b0;
    w_sdiv0  = 1'b0;
    case (Sel)
      OP_ADD:  begin w_single = {{(W-1){1'b0}}, w_add}; w_scarry = w_add[W]; end
      OP_SUB:  begin w_single = {{(W-1){1'b0}}, w_sub}; w_scarry = w_sub[W]; end
      OP_DIV:  begin w_single = {A, {W{1'b1}}};         w_sdiv0  = 1'b1;     end
      OP_SHL:  w_single = {{W{1'b0}}, A << w_amt};
      OP_SHR:  w_single = {{W{1'b0}}, A >> w_amt};
      OP_ROR:  w_single = {{W{1'b0}}, w_rr[W-1:0]};
      OP_ROL:  w_single = {{W{1'b0}}, w_rl[2*W-1:W]};
      OP_AND:  w_single = {{W{1'b0}}, A & B};
      OP_OR:   w_single = {{W{1'b0}}, A | B};
      OP_XOR:  w_single = {{W{1'b0}}, A ^ B};
      OP_NAND: w_single = {{W{1'b0}}, ~(A & B)};
      OP_NOR:  w_single = {{W{1'b0}}, ~(A | B)};
      OP_XNOR: w_single = {{W{1'b0}}, ~(A ^ B)};
      OP_GT:   w_single = {{(2*W-1){1'b0}}, (A > B)};
      OP_EQ:   w_single = {{(2*W-1){1'b0}}, (A == B)};
      default: w_single = '0;
    endcase
  end

  assign w_is_div = (Sel == OP_DIV);
  assign w_iter   = (Sel == OP_MUL) || (w_is_div && (B != '0));

  ula_muldiv #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .is_div (w_is_div),
    .A      (A),
    .B      (B),
    .res    (w_md_res),
    .last   (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result registers are written on the transition into FIN, so they are valid
  // in the same cycle that done is high.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    w_wdata     = w_single;
    w_wcarry    = w_scarry;
    w_wdiv0     = w_sdiv0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_iter) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_write     = 1'b1;
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_write     = 1'b1;
          w_wdata     = w_md_res;
          w_wcarry    = 1'b0;
          w_wdiv0     = 1'b0;
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_saida <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_div0  <= 1'b0;
    end else if (w_write) begin
      r_saida <= w_wdata;
      r_zero  <= (w_wdata == '0);
      r_carry <= w_wcarry;
      r_div0  <= w_wdiv0;
    end
  end

  assign Saida = r_saida;
  assign zero  = r_zero;
  assign carry = r_carry;
  assign div0  = r_div0;
  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_FIN);

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (W=8): stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including the cycle it arrives in.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     Sel = '0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] Saida;
  logic           busy, done, zero, carry, div0;

  typedef struct {
    logic [15:0] saida;
    logic        z;
    logic        c;
    logic        d;
    int          at;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  ula_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Sel   (Sel),
    .A     (A),
    .B     (B),
    .Saida (Saida),
    .busy  (busy),
    .done  (done),
    .zero  (zero),
    .carry (carry),
    .div0  (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, ".Saida"}, 32'(Saida), 32'(e.saida));
        chk({e.nm, ".zero"},  32'(zero),  32'(e.z));
        chk({e.nm, ".carry"}, 32'(carry), 32'(e.c));
        chk({e.nm, ".div0"},  32'(div0),  32'(e.d));
        chk({e.nm, ".cycle"}, 32'(cyc),   32'(e.at));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // lat: cycles from accept edge to done cycle; hold: cycles start stays high.
  task automatic issue(input string nm, input logic [3:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp, input logic ec,
                       input logic ed, input int lat, input int hold, input bit push);
    exp_t e;
    wait_idle();
    Sel = sel; A = a; B = b; start = 1'b1;
    if (push) begin
      e.saida = exp; e.z = (exp == 16'h0000); e.c = ec; e.d = ed;
      e.at = cyc + lat; e.nm = nm;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    A = 8'h00; B = 8'h00;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".Saida"}, 32'(Saida), 32'h0);
    chk({nm, ".busy"},  32'(busy),  32'h0);
    chk({nm, ".done"},  32'(done),  32'h0);
    chk({nm, ".zero"},  32'(zero),  32'h1);
    chk({nm, ".carry"}, 32'(carry), 32'h0);
    chk({nm, ".div0"},  32'(div0),  32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    issue("add_ff_01", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1, 1, 1'b1);
    // start held through the done cycle must not trigger a second operation
    issue("sub_1_1",   OP_SUB, 8'h01, 8'h01, 16'h0000, 1'b0, 1'b0, 1, 2, 1'b1);
    issue("sub_3_5",   OP_SUB, 8'h03, 8'h05, 16'h01FE, 1'b1, 1'b0, 1, 1, 1'b1);

    issue("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9, 1, 1'b1);
    @(negedge clk);
    Sel = OP_ADD; A = 8'h01; B = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    issue("add_pre_rst", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1, 1, 1'b1);
    issue("mul_abort",   OP_MUL, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 9, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    issue("add_1_1",   OP_ADD, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1, 1, 1'b1);

    issue("div_200_7", OP_DIV, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 9, 1, 1'b1);
    issue("div_5_0",   OP_DIV, 8'd5,   8'd0, 16'h05FF, 1'b0, 1'b1, 1, 1, 1'b1);

    issue("ror", OP_ROR, 8'h81, 8'h03, 16'h0030, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("rol", OP_ROL, 8'h81, 8'h03, 16'h000C, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("shl", OP_SHL, 8'h81, 8'h03, 16'h0008, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("shr", OP_SHR, 8'h81, 8'h03, 16'h0010, 1'b0, 1'b0, 1, 1, 1'b1);

    issue("and",  OP_AND,  8'hA5, 8'h5A, 16'h0000, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("or",   OP_OR,   8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("xor",  OP_XOR,  8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("nand", OP_NAND, 8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("nor",  OP_NOR,  8'hA5, 8'h5A, 16'h0000, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("xnor", OP_XNOR, 8'hA5, 8'h5A, 16'h0000, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("gt",   OP_GT,   8'hA5, 8'h5A, 16'h0001, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("eq0",  OP_EQ,   8'hA5, 8'h5A, 16'h0000, 1'b0, 1'b0, 1, 1, 1'b1);
    issue("eq1",  OP_EQ,   8'h33, 8'h33, 16'h0001, 1'b0, 1'b0, 1, 1, 1'b1);

    begin
      int k;
      k = 0;
      while (q.size() != 0 && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (3) @(negedge clk);
    chk("drain_outstanding", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
